// File: rtl/sif_xa_master.sv
// SIF xa-side initiator: valid/ready commands in, xa_wr_s/xa_rd_s strobe cycles out, read data back on a response stream.
// Optional SIF_XA_MASTER_STATS_EN adds saturating write/read counters with a synchronous clear.
module sif_xa_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] xa_addr,
  output logic [DATA_W-1:0] xa_data_wr,
  output logic              xa_wr_s,
  output logic              xa_rd_s,
  input  logic [DATA_W-1:0] xa_data_rd,
  output logic              busy
`ifdef SIF_XA_MASTER_STATS_EN
  ,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt,
  input  logic              stats_clr
`endif
);

  if (RD_LAT < 0 || RD_LAT > 7) begin : g_bad_lat
    $error("sif_xa_master: RD_LAT must be in 0..7");
  end

  localparam int         LAT_M1   = (RD_LAT > 0) ? RD_LAT - 1 : 0;
  localparam logic [2:0] LAT_INIT = 3'(LAT_M1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] xa_addr_q, xa_addr_d;
  logic [DATA_W-1:0] xa_wdat_q, xa_wdat_d;
  logic              wr_s_q, wr_s_d, rd_s_q, rd_s_d;
  logic              rv_q, rv_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d, busy_q, busy_d;
  logic              accept;

  assign accept = cmd_valid && ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    xa_addr_d = xa_addr_q;
    xa_wdat_d = xa_wdat_q;
    wr_s_d    = 1'b0;
    rd_s_d    = 1'b0;
    rv_d      = rv_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE, S_WR: begin
        if (accept) begin
          xa_addr_d = cmd_addr;
          if (cmd_wr) begin
            xa_wdat_d = cmd_wdata;
            wr_s_d    = 1'b1;
            state_d   = S_WR;
          end else begin
            rd_s_d  = 1'b1;
            state_d = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (RD_LAT == 0) begin
          rdata_d = xa_data_rd;
          raddr_d = xa_addr_q;
          rv_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = LAT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // xa_addr is held through the wait, so it still names the read
        if (cnt_q == 3'd0) begin
          rdata_d = xa_data_rd;
          raddr_d = xa_addr_q;
          rv_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE) || (state_d == S_WR);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      xa_addr_q <= '0;
      xa_wdat_q <= '0;
      wr_s_q    <= 1'b0;
      rd_s_q    <= 1'b0;
      rv_q      <= 1'b0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      xa_addr_q <= xa_addr_d;
      xa_wdat_q <= xa_wdat_d;
      wr_s_q    <= wr_s_d;
      rd_s_q    <= rd_s_d;
      rv_q      <= rv_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign busy       = busy_q;
  assign xa_addr    = xa_addr_q;
  assign xa_data_wr = xa_wdat_q;
  assign xa_wr_s    = wr_s_q;
  assign xa_rd_s    = rd_s_q;
  assign rsp_valid  = rv_q;
  assign rsp_addr   = raddr_q;
  assign rsp_rdata  = rdata_q;

`ifdef SIF_XA_MASTER_STATS_EN
  logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (stats_clr) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      if (wr_s_q && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
      if (rv_q && rsp_ready && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: doc/sif_xa_master.md
Name: sif_xa_master

Overview:
- Synthesizable initiator for the SIF xa-side access port. It converts a valid/ready command stream into xa_wr_s/xa_rd_s strobe cycles and returns read data on a valid/ready response stream.
- It sits between a local controller (or bus bridge) and any SIF xa-side responder, and replaces the behavioural driver used in benches.

Parameters:
- ADDR_W, 16, width of the xa address bus and command address.
- DATA_W, 16, width of the xa read/write data buses.
- RD_LAT, 1, cycles from the xa_rd_s cycle to valid xa_data_rd. Legal range 0..7; elaborate-time $error outside this range.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  command address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  response consumed when valid&&ready.
- rsp_addr  out  ADDR_W  address of the read being returned.
- rsp_rdata  out  DATA_W  captured read data.
- xa_addr  out  ADDR_W  SIF access address (registered).
- xa_data_wr  out  DATA_W  SIF write data (registered).
- xa_wr_s  out  1  SIF write strobe, one cycle per write.
- xa_rd_s  out  1  SIF read strobe, one cycle per read.
- xa_data_rd  in  DATA_W  SIF read data from the responder.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous assert, active-low, synchronous deassert (external synchronizer).
- Reset values:
  - all outputs 0, except cmd_ready = 0 during reset and 1 from the first edge after release;
  - xa_addr = 0, xa_data_wr = 0, strobes 0, rsp_* = 0;
  - state = IDLE.
- States are IDLE, WR, RD, WAIT, RESP. All outputs are registered; no combinational path from cmd_* or rsp_ready to any xa_* output.
- cmd_ready = 1 in IDLE and WR; 0 in RD, WAIT and RESP.
- IDLE:
  - Write accept: xa_addr and xa_data_wr are loaded, xa_wr_s = 1 in the next cycle, go to WR.
  - Read accept: xa_addr is loaded, xa_rd_s = 1 in the next cycle, go to RD.
- WR:
  - xa_wr_s is high for exactly this cycle.
  - A write accepted in WR goes to WR again, so back-to-back writes give continuous xa_wr_s with a new addr/data each cycle.
  - A read accepted in WR goes to RD. No accept goes to IDLE.
- RD:
  - xa_rd_s is high for exactly this cycle (call it cycle C).
  - RD_LAT = 0: xa_data_rd is captured at the edge ending C and the next state is RESP.
  - RD_LAT > 0: go to WAIT with a down-counter loaded to RD_LAT-1.
- WAIT:
  - The counter decrements each cycle.
  - When it reaches 0, xa_data_rd is captured at the edge ending cycle C+RD_LAT and the next state is RESP.
- RESP:
  - rsp_valid = 1 from cycle C+RD_LAT+1; rsp_addr = read address.
  - rsp_valid, rsp_addr and rsp_rdata stay stable until rsp_ready.
  - On the handshake, rsp_valid falls and the next state is IDLE.
  - rsp_ready high in the same cycle rsp_valid rises completes the response in one cycle.
- Boundary conditions:
  - Read-to-read minimum spacing is RD_LAT+3 cycles with rsp_ready tied high.
  - xa_addr and xa_data_wr hold their last value while idle; they are never driven X.
  - xa_wr_s and xa_rd_s are never high in the same cycle.
  - cmd_valid while cmd_ready = 0: no effect. The source must hold its command; this is a valid/ready rule, not checked.
  - rsp_ready while rsp_valid = 0: ignored.
  - Reset asserted mid-operation: immediate return to reset values. Any in-flight read and pending response are discarded, and no strobe is emitted after reset release until a new command is accepted.
  - Address and data are passed unchanged; there is no arithmetic on them.

Optional Feature:
- Macro: SIF_XA_MASTER_STATS_EN.
- Defined:
  - Adds output ports wr_cnt[15:0] and rd_cnt[15:0].
  - wr_cnt increments on each xa_wr_s cycle; rd_cnt increments on each rsp handshake.
  - Both saturate at 16'hFFFF and reset to 0.
  - Adds input stats_clr; stats_clr = 1 zeroes both counters on the next edge. Clear wins over a simultaneous increment.
- Undefined: the ports and logic are absent; otherwise behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 for 5 cycles with cmd_valid = 1 → xa_wr_s = xa_rd_s = 0, cmd_ready = 0, xa_addr = 0 throughout; cmd_ready = 1 on the first edge after release.
- Single write addr 16'h0010, data 16'hA5A5 → exactly one xa_wr_s cycle, one cycle after accept, with xa_addr = 0010 and xa_data_wr = A5A5; busy returns to 0 the following cycle.
- Four back-to-back writes to addr 0..3, data 16'h1000..16'h1003 → four consecutive xa_wr_s cycles with matching addr/data; cmd_ready stays high throughout.
- Read addr 16'h0042 with RD_LAT = 2 and the responder returning 16'hBEEF on cycle C+2 → rsp_valid in cycle C+3 with rsp_rdata = BEEF and rsp_addr = 0042. Hold rsp_ready = 0 for 4 cycles: outputs stay stable and cmd_ready = 0.
- Read followed immediately by write (cmd_valid held) → write is not accepted until the cycle after the rsp handshake; xa_wr_s and xa_rd_s never overlap. Repeat with RD_LAT = 0.
- Reset pulse in WAIT → rsp_valid never asserts for the aborted read; the next read after release returns correct data. With SIF_XA_MASTER_STATS_EN: 3 writes and 2 reads give wr_cnt = 3, rd_cnt = 2; stats_clr gives 0/0.
